// File: rtl/ysyx_25030081_idu_ctrl.sv
// Decode-stage controller: classifies opcodes into an ext_op, holds the
// result in a one-entry output register and issues it to the EXU.
module ysyx_25030081_idu_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [24:0]           out_inst,
    output logic [2:0]            out_ext_op,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  out_rd_wen,
    output logic                  out_illegal,
    input  logic                  flush,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    state_t                state_q, state_d;
    logic [24:0]           inst_q, inst_d;
    logic [2:0]            ext_op_q, ext_op_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  rd_wen_q, rd_wen_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       issue;
    logic [2:0] dec_ext_op;
    logic       dec_rd_wen;
    logic       dec_illegal;

    assign accept = in_valid && in_ready;
    assign issue  = out_valid && out_ready;

    // Opcode classification of the incoming instruction
    always_comb begin
        dec_ext_op  = EXT_I;
        dec_rd_wen  = 1'b0;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            OP_LUI, OP_AUIPC: begin
                dec_ext_op = EXT_U;
                dec_rd_wen = 1'b1;
            end
            OP_JAL: begin
                dec_ext_op = EXT_J;
                dec_rd_wen = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_REG: begin
                dec_ext_op = EXT_I;
                dec_rd_wen = 1'b1;
            end
            OP_STORE: dec_ext_op = EXT_S;
            OP_BRANCH: dec_ext_op = EXT_B;
            OP_SYSTEM: dec_ext_op = EXT_I;
            default: dec_illegal = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush beats halt, so a discarded illegal entry never stops the core
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d = S_EMPTY;
                end else if (issue && illegal_q) begin
                    state_d = S_HALT;
                end else if (issue && !accept) begin
                    state_d = S_EMPTY;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_FULL);
        halted    = (state_q == S_HALT);
        in_ready  = !flush &&
                    ((state_q == S_EMPTY) ||
                     ((state_q == S_FULL) && out_ready));
    end

    always_comb begin
        inst_d    = inst_q;
        ext_op_d  = ext_op_q;
        pc_d      = pc_q;
        rd_wen_d  = rd_wen_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (accept) begin
            inst_d    = in_inst[31:7];
            ext_op_d  = dec_ext_op;
            pc_d      = in_pc;
            rd_wen_d  = dec_rd_wen;
            illegal_d = dec_illegal;
        end
        if (issue) begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q    <= '0;
            ext_op_q  <= EXT_I;
            pc_q      <= PC_RESET;
            rd_wen_q  <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            inst_q    <= inst_d;
            ext_op_q  <= ext_op_d;
            pc_q      <= pc_d;
            rd_wen_q  <= rd_wen_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_inst    = inst_q;
    assign out_ext_op  = ext_op_q;
    assign out_pc      = pc_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_illegal = illegal_q;
    assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_25030081_idu_ctrl.sv
// Directed bench for ysyx_25030081_idu_ctrl: stream, backpressure,
// flush, illegal/halt, reset and a 4-bit counter wrap instance.
module tb_ysyx_25030081_idu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush;
    logic        in_ready, out_valid, out_rd_wen, out_illegal, halted;
    logic [31:0] in_inst, in_pc, out_pc, issue_cnt;
    logic [24:0] out_inst;
    logic [2:0]  out_ext_op;

    logic        w_rst_n, w_in_valid, w_out_ready, w_flush;
    logic        w_in_ready, w_out_valid, w_rd_wen, w_illegal, w_halted;
    logic [31:0] w_in_inst;
    logic [3:0]  w_in_pc, w_out_pc, w_cnt;
    logic [24:0] w_out_inst;
    logic [2:0]  w_ext_op;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ysyx_25030081_idu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_ext_op(out_ext_op),
        .out_pc(out_pc), .out_rd_wen(out_rd_wen),
        .out_illegal(out_illegal), .flush(flush),
        .halted(halted), .issue_cnt(issue_cnt)
    );

    ysyx_25030081_idu_ctrl #(.DATA_WIDTH(4), .PC_RESET(4'h8)) u_w4 (
        .clk(clk), .rst_n(w_rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_inst(w_in_inst), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_inst(w_out_inst), .out_ext_op(w_ext_op),
        .out_pc(w_out_pc), .out_rd_wen(w_rd_wen),
        .out_illegal(w_illegal), .flush(w_flush),
        .halted(w_halted), .issue_cnt(w_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_pc !== 32'h8000_0000) $display("FAIL reset_pc got=%0h exp=80000000", out_pc);
        else pass_cnt++;
        total_cnt++;
        if ({out_inst, out_ext_op, out_rd_wen, out_illegal, halted} !== '0)
            $display("FAIL reset_fields got=%0h exp=0",
                     {out_inst, out_ext_op, out_rd_wen, out_illegal, halted});
        else pass_cnt++;
        total_cnt++;
        if (issue_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", issue_cnt);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] v [5] = '{32'h00500093, 32'h12345137, 32'h00112223,
                               32'h00000463, 32'h008000EF};
        logic [2:0]  e_op [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        logic        e_wen [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] cur;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cur = v[k];
            in_valid = 1'b1; in_inst = cur; in_pc = 32'h100 + 32'(4 * k);
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got=%0b exp=1", k, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_ext_op !== e_op[k] || out_rd_wen !== e_wen[k])
                $display("FAIL stream_dec[%0d] got=%0b/%0b/%0b exp=1/%0b/%0b",
                         k, out_valid, out_ext_op, out_rd_wen, e_op[k], e_wen[k]);
            else pass_cnt++;
            total_cnt++;
            if (out_inst !== cur[31:7] || out_pc !== 32'h100 + 32'(4 * k))
                $display("FAIL stream_data[%0d] got=%0h/%0h exp=%0h/%0h",
                         k, out_inst, out_pc, cur[31:7], 32'h100 + 32'(4 * k));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (issue_cnt !== 32'd5 || out_valid !== 1'b0)
            $display("FAIL stream_cnt got=%0d/%0b exp=5/0", issue_cnt, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] a = 32'h00500093;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = a; in_pc = 32'h200;
        tick();
        in_inst = 32'h12345137; in_pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%0b exp=0", k, in_ready);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1 || out_inst !== a[31:7] || out_pc !== 32'h200)
                $display("FAIL bp_hold[%0d] got=%0b/%0h/%0h exp=1/%0h/200",
                         k, out_valid, out_inst, out_pc, a[31:7]);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got=%0b exp=1", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_ext_op !== 3'b001 || out_pc !== 32'h204 || issue_cnt !== 32'd6)
            $display("FAIL bp_next got=%0b/%0h/%0d exp=001/204/6", out_ext_op, out_pc, issue_cnt);
        else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (issue_cnt !== 32'd7 || out_valid !== 1'b0)
            $display("FAIL bp_drain got=%0d/%0b exp=7/0", issue_cnt, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFFF_FFFF; in_pc = 32'h300;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1)
            $display("FAIL flush_load got=%0b/%0b exp=1/1", out_valid, out_illegal);
        else pass_cnt++;
        in_inst = 32'h00500093; flush = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b exp=0", in_ready);
        else pass_cnt++;
        tick();
        flush = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_after got=%0b/%0b/%0b exp=0/0/1", out_valid, halted, in_ready);
        else pass_cnt++;
        in_inst = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total_cnt++;
        if (issue_cnt !== 32'd8 || halted !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_issue got=%0d/%0b/%0b exp=8/0/0", issue_cnt, halted, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'h400;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ext_op !== 3'b000 || out_rd_wen !== 1'b0)
            $display("FAIL ill_entry got=%0b/%0b/%0b/%0b exp=1/1/0/0",
                     out_valid, out_illegal, out_ext_op, out_rd_wen);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total_cnt++;
        if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || issue_cnt !== 32'd9)
            $display("FAIL ill_halt got=%0b/%0b/%0b/%0d exp=1/0/0/9",
                     halted, out_valid, in_ready, issue_cnt);
        else pass_cnt++;
        in_valid = 1'b1; in_inst = 32'h00500093; flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        #1;
        total_cnt++;
        if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL ill_sticky got=%0b/%0b/%0b exp=1/0/0", halted, in_ready, out_valid);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (halted !== 1'b0 || out_pc !== 32'h8000_0000 || issue_cnt !== 32'd0 ||
            out_illegal !== 1'b0 || out_inst !== 25'd0 || in_ready !== 1'b1)
            $display("FAIL ill_reset got=%0b/%0h/%0d/%0b/%0h/%0b exp=0/80000000/0/0/0/1",
                     halted, out_pc, issue_cnt, out_illegal, out_inst, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h500;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL mid_full got=%0b exp=1", out_valid);
        else pass_cnt++;
        in_inst = 32'h12345137; in_pc = 32'h504; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || issue_cnt !== 32'd0 || out_inst !== 25'd0 || out_pc !== 32'h8000_0000)
            $display("FAIL mid_reset got=%0b/%0d/%0h/%0h exp=0/0/0/80000000",
                     out_valid, issue_cnt, out_inst, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        w_rst_n = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1; w_flush = 1'b0;
        w_in_inst = 32'h00500093; w_in_pc = 4'h4;
        tick();
        w_rst_n = 1'b1;
        #1;
        total_cnt++;
        if (w_out_pc !== 4'h8 || w_cnt !== 4'h0)
            $display("FAIL wrap_reset got=%0h/%0h exp=8/0", w_out_pc, w_cnt);
        else pass_cnt++;
        w_in_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 16) begin
                total_cnt++;
                if (w_cnt !== 4'hF) $display("FAIL wrap_f got=%0h exp=f", w_cnt);
                else pass_cnt++;
            end
            if (i == 17) begin
                total_cnt++;
                if (w_cnt !== 4'h0) $display("FAIL wrap_0 got=%0h exp=0", w_cnt);
                else pass_cnt++;
            end
            if (i == 18) begin
                total_cnt++;
                if (w_cnt !== 4'h1) $display("FAIL wrap_1 got=%0h exp=1", w_cnt);
                else pass_cnt++;
            end
        end
        w_in_valid = 1'b0;
    endtask

    initial begin
        w_rst_n = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_flush = 1'b0;
        w_in_inst = '0; w_in_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_25030081_idu_ctrl.md
Name: ysyx_25030081_idu_ctrl

Overview:
Decode-stage controller that sequences the immediate-extension datapath. Accepts fetched instructions from the IFU over a valid/ready handshake, classifies the opcode, and generates the 3-bit ext_op (I/U/S/B/J) together with a few control bits. Holds them in a single-entry pipeline register and issues them to the EXU over a second valid/ready handshake. Also handles flush, halts on an illegal opcode, and keeps an issued-instruction counter.

Parameters:
DATA_WIDTH, 32, width of PC and issue counter
PC_RESET, 32'h8000_0000, value of out_pc after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  IFU has an instruction
in_ready  output  1  controller can accept this cycle
in_inst  input  32  fetched instruction
in_pc  input  DATA_WIDTH  PC of in_inst
out_valid  output  1  registered decode result valid
out_ready  input  1  EXU accepts this cycle
out_inst  output  25  registered inst[31:7]; feeds the ext unit inst port
out_ext_op  output  3  000 I, 001 U, 010 S, 011 B, 100 J
out_pc  output  DATA_WIDTH  registered PC
out_rd_wen  output  1  instruction writes rd
out_illegal  output  1  issued entry is illegal
flush  input  1  discard held entry (redirect)
halted  output  1  controller stopped after an illegal instruction
issue_cnt  output  DATA_WIDTH  count of completed out handshakes

Behaviour:
- Reset (rst_n=0 at edge): state EMPTY. out_valid=0, out_inst=0, out_ext_op=000, out_pc=PC_RESET, out_rd_wen=0, out_illegal=0, halted=0, issue_cnt=0. Reset overrides every other input, including mid-handshake.
- States: EMPTY, FULL, HALT.
- in_ready = !flush && (EMPTY || (FULL && out_ready)). In HALT, in_ready=0. This is combinational; out_ready→in_ready pass-through is allowed.
- Accept: in_valid && in_ready. On the next edge the output register loads the decode of in_inst, and the state becomes FULL. Latency from accept to out_valid is 1 cycle.
- Issue: out_valid && out_ready. issue_cnt increments by 1 on each issue and wraps from 2^DATA_WIDTH-1 to 0.
  - Issue without a simultaneous accept: FULL→EMPTY.
  - Issue with a simultaneous accept: stays FULL with the new entry; there is no bubble.
- out_valid=1 exactly in FULL. Outputs hold stable while out_valid && !out_ready.
- Decode uses in_inst[6:0]; in_inst[1:0]!=2'b11 is illegal.
  - 0110111 LUI, 0010111 AUIPC: ext_op 001, rd_wen 1.
  - 1101111 JAL: ext_op 100, rd_wen 1.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM: ext_op 000, rd_wen 1.
  - 0100011 STORE: ext_op 010, rd_wen 0.
  - 1100011 BRANCH: ext_op 011, rd_wen 0.
  - 0110011 OP: ext_op 000 (unused), rd_wen 1.
  - 1110011 SYSTEM: ext_op 000, rd_wen 0.
  - Any other opcode: illegal=1, ext_op 000, rd_wen 0.
- Illegal entry: issued normally with out_illegal=1. On its issue handshake the state goes to HALT and halted=1. HALT is left only by reset; flush does not clear it.
- flush=1: the next state is EMPTY (from EMPTY/FULL) and out_valid drops next cycle. No accept in the flush cycle. An issue handshake in the same cycle still counts in issue_cnt; a flushed illegal entry does not cause HALT.
- A held FULL entry with out_ready=0 and in_valid=1 gives in_ready=0 (backpressure); no entry is overwritten.

Test Plan:
- Reset then back-to-back stream with out_ready=1: 0x00500093 (addi), 0x12345137 (lui), 0x00112223 (sw), 0x00000463 (beq), 0x008000EF (jal) → one cycle later each, ext_op 000/001/010/011/100, rd_wen 1/1/0/0/1; in_ready stays 1; issue_cnt=5.
- Backpressure: accept 0x00500093 with out_ready=0 for 3 cycles while in_valid=1 with 0x12345137 → in_ready=0, out_inst/out_pc stable for 3 cycles. Raise out_ready → same-cycle accept of the lui; next cycle ext_op=001.
- Illegal: issue 0x00000000 → out_illegal=1. After its handshake, halted=1 and in_ready=0 permanently, even with flush=1. rst_n=0 for one edge → all outputs back to reset values, out_pc=0x80000000.
- Flush: FULL with illegal 0xFFFFFFFF, out_ready=0, flush=1 → next cycle out_valid=0 and halted=0; in_ready=0 during the flush cycle and 1 the cycle after.
- Counter wrap: run with DATA_WIDTH=4 for 17 issues → issue_cnt reads 0xF then 0x0 then 0x1.
- Reset mid-handshake: rst_n=0 in the same cycle as in_valid=1, out_ready=1 in FULL → next cycle out_valid=0 and issue_cnt=0; the accepted entry is discarded.
